// File: rtl/cpu_bus_pkg.sv
// Shared bus code space for the source encoder and destination decoder.
// Holds code widths, named register codes and the decoder state type.
package cpu_bus_pkg;

    localparam int CODE_W   = 5;
    localparam int NUM_DEST = 24;
    localparam int PULSE_W  = 4;

    localparam logic [CODE_W-1:0] CODE_NONE   = 5'd0;
    localparam logic [CODE_W-1:0] CODE_R0     = 5'd1;
    localparam logic [CODE_W-1:0] CODE_R1     = 5'd2;
    localparam logic [CODE_W-1:0] CODE_R2     = 5'd3;
    localparam logic [CODE_W-1:0] CODE_R3     = 5'd4;
    localparam logic [CODE_W-1:0] CODE_R4     = 5'd5;
    localparam logic [CODE_W-1:0] CODE_R5     = 5'd6;
    localparam logic [CODE_W-1:0] CODE_R6     = 5'd7;
    localparam logic [CODE_W-1:0] CODE_R7     = 5'd8;
    localparam logic [CODE_W-1:0] CODE_R8     = 5'd9;
    localparam logic [CODE_W-1:0] CODE_R9     = 5'd10;
    localparam logic [CODE_W-1:0] CODE_R10    = 5'd11;
    localparam logic [CODE_W-1:0] CODE_R11    = 5'd12;
    localparam logic [CODE_W-1:0] CODE_R12    = 5'd13;
    localparam logic [CODE_W-1:0] CODE_R13    = 5'd14;
    localparam logic [CODE_W-1:0] CODE_R14    = 5'd15;
    localparam logic [CODE_W-1:0] CODE_R15    = 5'd16;
    localparam logic [CODE_W-1:0] CODE_HI     = 5'd17;
    localparam logic [CODE_W-1:0] CODE_LO     = 5'd18;
    localparam logic [CODE_W-1:0] CODE_ZHI    = 5'd19;
    localparam logic [CODE_W-1:0] CODE_ZLO    = 5'd20;
    localparam logic [CODE_W-1:0] CODE_PC     = 5'd21;
    localparam logic [CODE_W-1:0] CODE_MDR    = 5'd22;
    localparam logic [CODE_W-1:0] CODE_INPORT = 5'd23;
    localparam logic [CODE_W-1:0] CODE_C      = 5'd24;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } bus_state_t;

endpackage

// File: rtl/bus_dest_decoder_onehot.sv
// Combinational destination code to one-hot load-enable decode,
// with flags for the "no destination" code and for in-range codes.
module dest_code_onehot #(
    parameter int CODE_W   = cpu_bus_pkg::CODE_W,
    parameter int NUM_DEST = cpu_bus_pkg::NUM_DEST
) (
    input  logic [CODE_W-1:0]   code,
    output logic [NUM_DEST-1:0] onehot,
    output logic                isLegal,
    output logic                isNone
);
    import cpu_bus_pkg::*;

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            onehot[i] = (int'(code) == int'(i) + 1);
        end
    end

    assign isNone  = (code == '0);
    assign isLegal = !isNone && (int'(code) <= NUM_DEST);

endmodule

// File: rtl/bus_dest_decoder.sv
// Bus destination decoder: valid/ready code in, timed one-hot register load pulses out.
// Optional DEST_SKID_EN adds a one-entry pending buffer for back-to-back pulses.
module bus_dest_decoder #(
    parameter int CODE_W    = cpu_bus_pkg::CODE_W,
    parameter int NUM_DEST  = cpu_bus_pkg::NUM_DEST,
    parameter int PULSE_LEN = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [CODE_W-1:0]   destCode,
    input  logic                destValid,
    output logic                destReady,
    output logic [NUM_DEST-1:0] loadEnable,
    output logic                busy,
    output logic                illegalCode,
    input  logic                errClear
);
    import cpu_bus_pkg::*;

    localparam logic [PULSE_W-1:0] CNT_LOAD = PULSE_W'(PULSE_LEN - 1);

    bus_state_t          state;
    logic [PULSE_W-1:0]  cnt;
    logic [NUM_DEST-1:0] le_q;
    logic                ill_q;

    logic [CODE_W-1:0]   dec_code;
    logic [NUM_DEST-1:0] dec_onehot;
    logic                dec_legal;
    logic                dec_none;
    logic                accept;
    logic                last_cycle;
    logic                take;

    assign accept     = destValid && destReady;
    assign last_cycle = (state == LOAD) && (cnt == '0);

    dest_code_onehot #(
        .CODE_W   (CODE_W),
        .NUM_DEST (NUM_DEST)
    ) u_decode (
        .code    (dec_code),
        .onehot  (dec_onehot),
        .isLegal (dec_legal),
        .isNone  (dec_none)
    );

`ifdef DEST_SKID_EN
    logic              pend_valid;
    logic [CODE_W-1:0] pend_code;

    assign destReady = !pend_valid;
    assign dec_code  = pend_valid ? pend_code : destCode;
    // The last LOAD cycle consumes the buffered code, or a same-cycle accept straight through.
    assign take      = (state == IDLE) ? accept : (last_cycle && (pend_valid || accept));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pend_valid <= 1'b0;
            pend_code  <= '0;
        end else if ((state == LOAD) && !last_cycle && accept) begin
            pend_valid <= 1'b1;
            pend_code  <= destCode;
        end else if (last_cycle) begin
            pend_valid <= 1'b0;
        end
    end
`else
    assign destReady = (state == IDLE);
    assign dec_code  = destCode;
    assign take      = accept;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            cnt   <= '0;
            le_q  <= '0;
            ill_q <= 1'b0;
        end else begin
            if (errClear) begin
                ill_q <= 1'b0;
            end
            if (take && !dec_legal && !dec_none) begin
                ill_q <= 1'b1;
            end

            if (take && dec_legal) begin
                state <= LOAD;
                le_q  <= dec_onehot;
                cnt   <= CNT_LOAD;
            end else if (last_cycle) begin
                state <= IDLE;
                le_q  <= '0;
                cnt   <= '0;
            end else if (state == LOAD) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign loadEnable  = le_q;
    assign busy        = (state == LOAD);
    assign illegalCode = ill_q;

endmodule

// File: tb/tb_bus_dest_decoder.sv
// Self-checking bench for bus_dest_decoder: two instances (pulse length 1 and 3)
// driven by shared stimulus and compared against a queue-based pulse model.
module tb_bus_dest_decoder;
    import cpu_bus_pkg::*;

    localparam int NDEST = 24;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        destValid = 1'b0;
    logic        errClear = 1'b0;
    logic [4:0]  destCode = '0;

    logic        rdy_a, busy_a, ill_a;
    logic        rdy_b, busy_b, ill_b;
    logic [23:0] le_a, le_b;

    int checks = 0;
    int errors = 0;

    logic [23:0] qa[$];
    logic [23:0] qb[$];
    logic [23:0] exp_le_a, exp_le_b;
    logic        exp_ill_a, exp_ill_b;
    bit          model_on;

    always #5 clock = ~clock;

    bus_dest_decoder #(.CODE_W(5), .NUM_DEST(24), .PULSE_LEN(1)) u_dut_a (
        .clock(clock), .clear(clear), .destCode(destCode), .destValid(destValid),
        .destReady(rdy_a), .loadEnable(le_a), .busy(busy_a), .illegalCode(ill_a),
        .errClear(errClear)
    );

    bus_dest_decoder #(.CODE_W(5), .NUM_DEST(24), .PULSE_LEN(3)) u_dut_b (
        .clock(clock), .clear(clear), .destCode(destCode), .destValid(destValid),
        .destReady(rdy_b), .loadEnable(le_b), .busy(busy_b), .illegalCode(ill_b),
        .errClear(errClear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] hot(input int c);
        return 24'(1) << (c - 1);
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        exp_le_a  = '0;
        exp_le_b  = '0;
        exp_ill_a = 1'b0;
        exp_ill_b = 1'b0;
    endtask

    // Each accepted legal code schedules PULSE_LEN cycles of its one-hot value.
    task automatic model_edge();
        bit acc_a, acc_b, legal;
        int c;
        c     = int'(destCode);
        legal = (c >= 1) && (c <= NDEST);
        acc_a = destValid && (exp_le_a == '0);
        acc_b = destValid && (exp_le_b == '0);
        exp_ill_a = exp_ill_a & ~errClear;
        exp_ill_b = exp_ill_b & ~errClear;
        if (acc_a) begin
            if (legal) qa.push_back(hot(c));
            else if (c != 0) exp_ill_a = 1'b1;
        end
        if (acc_b) begin
            if (legal) repeat (3) qb.push_back(hot(c));
            else if (c != 0) exp_ill_b = 1'b1;
        end
        exp_le_a = (qa.size() > 0) ? qa.pop_front() : '0;
        exp_le_b = (qb.size() > 0) ? qb.pop_front() : '0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (model_on) model_edge();
        #1;
        check("onehot0_a", 32'($onehot0(le_a)), 1);
        check("onehot0_b", 32'($onehot0(le_b)), 1);
        if (model_on) begin
            check("model_le_a",   le_a,   exp_le_a);
            check("model_le_b",   le_b,   exp_le_b);
            check("model_busy_a", busy_a, exp_le_a != '0);
            check("model_busy_b", busy_b, exp_le_b != '0);
            check("model_rdy_a",  rdy_a,  exp_le_a == '0);
            check("model_rdy_b",  rdy_b,  exp_le_b == '0);
            check("model_ill_a",  ill_a,  exp_ill_a);
            check("model_ill_b",  ill_b,  exp_ill_b);
        end
    endtask

    initial begin
`ifdef DEST_SKID_EN
        model_on = 1'b0;
`else
        model_on = 1'b1;
`endif
        model_reset();
        #12;
        check("rst_le_a",   le_a,   0);
        check("rst_le_b",   le_b,   0);
        check("rst_busy_a", busy_a, 0);
        check("rst_ill_b",  ill_b,  0);
        clear = 1'b1;
        tick();
        check("rst_rdy_a", rdy_a, 1);
        check("rst_rdy_b", rdy_b, 1);

`ifdef DEST_SKID_EN
        destValid = 1'b1;
        destCode  = CODE_R0;
        tick();
        check("skid_a_1", le_a, 24'h000001);
        check("skid_b_1", le_b, 24'h000001);
        destCode = CODE_R1;
        tick();
        destValid = 1'b0;
        check("skid_a_2", le_a, 24'h000002);
        check("skid_b_hold", le_b, 24'h000001);
        check("skid_b_full", rdy_b, 0);
        tick();
        check("skid_a_end", le_a, 0);
        check("skid_b_3", le_b, 24'h000001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("skid_b_next", le_b, 24'h000002);
            check("skid_b_busy", busy_b, 1);
        end
        tick();
        check("skid_b_end", le_b, 0);
        check("skid_b_rdy", rdy_b, 1);
`else
        destValid = 1'b1;
        destCode  = CODE_HI;
        tick();
        destValid = 1'b0;
        check("hi_pulse_a", le_a, 24'h010000);
        tick();
        check("hi_end_a", le_a, 0);
        check("hi_rdy_a", rdy_a, 1);
        repeat (3) tick();

        destValid = 1'b1;
        destCode  = CODE_C;
        tick();
        destValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("c_pulse_b", le_b, 24'h800000);
            check("c_busy_b", busy_b, 1);
            check("c_rdy_b", rdy_b, 0);
            tick();
        end
        check("c_end_b", le_b, 0);
        check("c_idle_b", busy_b, 0);

        destValid = 1'b1;
        destCode  = CODE_NONE;
        tick();
        destValid = 1'b0;
        check("none_le_a", le_a, 0);
        check("none_ill_a", ill_a, 0);
        destValid = 1'b1;
        destCode  = 5'd31;
        tick();
        destValid = 1'b0;
        check("bad_le_b", le_b, 0);
        check("bad_ill_a", ill_a, 1);
        check("bad_ill_b", ill_b, 1);
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        check("errclr_a", ill_a, 0);

        destValid = 1'b1;
        destCode  = 5'd25;
        errClear  = 1'b1;
        tick();
        destValid = 1'b0;
        errClear  = 1'b0;
        check("set_wins_a", ill_a, 1);
        errClear = 1'b1;
        tick();
        errClear = 1'b0;

        for (int c = 1; c <= NDEST; c++) begin
            destValid = 1'b1;
            destCode  = 5'(c);
            tick();
            destValid = 1'b0;
            check("sweep_a", le_a, hot(c));
            check("sweep_b", le_b, hot(c));
            repeat (3) tick();
        end

        repeat (600) begin
            destValid = 1'($urandom_range(0, 1));
            destCode  = 5'($urandom_range(0, 31));
            errClear  = ($urandom_range(0, 15) == 0);
            tick();
        end
`endif

        destValid = 1'b0;
        errClear  = 1'b0;
        repeat (4) tick();
        destValid = 1'b1;
        destCode  = CODE_R4;
        tick();
        destValid = 1'b0;
        check("mid_pulse_b", le_b, 24'h000010);
        #2;
        clear = 1'b0;
        #1;
        check("mid_rst_le_a",   le_a,   0);
        check("mid_rst_le_b",   le_b,   0);
        check("mid_rst_busy_b", busy_b, 0);
        model_reset();
        @(posedge clock);
        #1;
        clear = 1'b1;
        tick();
        check("post_rst_rdy_b", rdy_b, 1);
        check("post_rst_ill_a", ill_a, 0);
        check("post_rst_le_b",  le_b,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
